saph_span_coeff_gen: RTL
========================

// Module: saph_span_coeff_gen
// PURPOSE
// - Per-span gradient coefficient generator; sits directly upstream of the per-channel colour interpolators.
// - Accepts one span command: pixel count, start RGBA, end RGBA.
// - Emits one pixel beat per pixel, carrying an 8-bit coefficient that ramps 0 -> 255 across the span, plus both endpoint colours.
// - Downstream blends each channel as from + (to - from) * coeff / 256.
// PARAMETERS
// - LEN_W   12  width of span length/index; spans of 1..2^LEN_W pixels
// - FRAC_W   8  fractional bits of step/accumulator; also sets divider cycles
// PORTS
// - clk         in   1       clock; all state on rising edge
// - rst_n       in   1       asynchronous, active-low reset
// - cmd_valid   in   1       span command valid
// - cmd_ready   out  1       span command accepted when valid & ready
// - cmd_len_m1  in   LEN_W   pixel count minus one (0 = 1 pixel)
// - cmd_from    in   32      start colour RGBA8888
// - cmd_to      in   32      end colour RGBA8888
// - px_valid    out  1       pixel beat valid
// - px_ready    in   1       downstream accepts beat when valid & ready
// - px_coeff    out  8       interpolation coefficient for this pixel
// - px_from     out  32      latched cmd_from
// - px_to       out  32      latched cmd_to
// - px_idx      out  LEN_W   pixel index within span, 0-based
// - px_last     out  1       high on final pixel of span
// - busy        out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; cmd_ready=1; px_valid=0; busy=0; px_coeff, px_idx, px_last=0; px_from, px_to=0; acc, step=0.
// - Reset mid-span: span is dropped with no further beats; accepting new commands resumes on the first edge after rst_n rises.
// - States:
//   - IDLE: cmd_ready=1. On cmd handshake, latch len_m1, from and to; clear idx and acc.
//     - If len_m1==0: step=0 and go to RUN.
//     - Otherwise go to DIV.
//   - DIV: restoring divider computes step = floor((255 << FRAC_W) / len_m1).
//     - One quotient bit per cycle; exactly 8+FRAC_W cycles.
//     - Then go to RUN. cmd_ready=0 and px_valid=0 throughout.
//   - RUN: px_valid=1.
//     - On px handshake with idx != len_m1: idx += 1, acc += step.
//     - On px handshake with idx == len_m1: go to IDLE.
// - Coefficient:
//   - px_coeff = acc[FRAC_W+7 : FRAC_W].
//   - Forced to 8'hFF when px_last and len_m1 != 0.
//   - 1-pixel span: coeff 0, last 1.
// - px_last = (idx == len_m1), valid only while px_valid.
// - Widths: acc and step are 8+FRAC_W bits unsigned. len_m1*step <= 255<<FRAC_W, so acc never overflows and no saturation logic is needed.
// - Divider: dividend 8+FRAC_W bits, divisor LEN_W bits, partial remainder LEN_W+1 bits. No divide-by-zero path; len_m1==0 bypasses DIV.
// - Command-to-first-beat latency:
//   - 1 cycle if len_m1==0.
//   - 9+FRAC_W cycles otherwise.
// - Back-to-back spans: IDLE accepts no command in the cycle the last beat retires, so there is one bubble cycle between spans.
// - Backpressure: while px_valid & !px_ready, every px_* output holds stable. px_valid never drops without a handshake (except reset).
// - cmd_* inputs are ignored outside IDLE; latched values are not affected by later input changes.
// CONFIGURATION
// - SAPH_SPAN_SKID_EN defined:
//   - All px_* outputs come from a 2-entry skid buffer; all px_* outputs are registered.
//   - px_ready does not feed the RUN-state advance combinationally.
//   - Adds +1 cycle to command-to-first-beat latency.
//   - Full throughput of one beat per cycle is preserved.
// - SAPH_SPAN_SKID_EN undefined:
//   - px_* outputs are driven directly from RUN-state registers.
//   - px_ready feeds idx/acc advance combinationally.
//   - Latency as stated in BEHAVIOUR.
// TESTING
// - FRAC_W=8; cmd_len_m1=3; px_ready=1 -> coeff 0,85,170,255; idx 0..3; last only on idx 3; first beat 17 cycles after cmd handshake.
// - cmd_len_m1=0 -> single beat on next cycle; coeff 0, idx 0, last 1; returns to IDLE with cmd_ready=1.
// - cmd_len_m1=255 -> step=256; coeff equals idx for idx 0..254, coeff 255 on last.
// - cmd_len_m1=1 -> coeff 0 then 255. Hold px_ready=0 for 5 cycles on beat 0 -> all px_* held stable, idx does not advance.
// - Second cmd presented during RUN -> cmd_ready=0 until IDLE. Changes to cmd_from during DIV/RUN do not alter px_from.
// - Assert rst_n=0 asynchronously mid-RUN -> px_valid=0, busy=0 immediately; a new cmd after release is handled normally.

Source files
------------

// File: rtl/saph_span_coeff_gen.sv
// Per-span gradient coefficient generator: one command in, one beat per pixel out with a 0..255 ramp.
// Optional SAPH_SPAN_SKID_EN registers all px_* outputs through a 2-entry skid buffer.
module saph_span_coeff_gen #(
    parameter int LEN_W  = 12,
    parameter int FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len_m1,
    input  logic [31:0]      cmd_from,
    input  logic [31:0]      cmd_to,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [7:0]       px_coeff,
    output logic [31:0]      px_from,
    output logic [31:0]      px_to,
    output logic [LEN_W-1:0] px_idx,
    output logic             px_last,
    output logic             busy
);

    localparam int ACC_W = 8 + FRAC_W;
    localparam int CNT_W = $clog2(ACC_W);
    localparam logic [ACC_W-1:0] DIVIDEND = {8'hFF, {FRAC_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    state_t            state, state_next;
    logic [LEN_W-1:0]  len_m1, idx;
    logic [31:0]       from_q, to_q;
    logic [ACC_W-1:0]  acc, step;
    logic [LEN_W:0]    div_rem, rem_shift, rem_next;
    logic [CNT_W-1:0]  div_cnt;
    logic              div_ge;
    logic              cmd_fire, core_valid, core_ready, core_fire, core_last;
    logic [7:0]        core_coeff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cmd_fire) state_next = (cmd_len_m1 == '0) ? RUN : DIV;
            DIV:  if (div_cnt == '0) state_next = RUN;
            RUN:  if (core_fire && core_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        core_valid = (state == RUN);
    end

    assign cmd_fire   = cmd_valid & cmd_ready;
    assign core_fire  = core_valid & core_ready;
    assign core_last  = (idx == len_m1);
    assign core_coeff = (core_last && len_m1 != '0) ? 8'hFF : acc[FRAC_W+7:FRAC_W];

    // Restoring division: step doubles as the dividend shifter, quotient bits enter at the LSB.
    always_comb begin
        rem_shift = {div_rem[LEN_W-1:0], step[ACC_W-1]};
        div_ge    = (rem_shift >= {1'b0, len_m1});
        rem_next  = div_ge ? (rem_shift - {1'b0, len_m1}) : rem_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_m1  <= '0;
            idx     <= '0;
            from_q  <= '0;
            to_q    <= '0;
            acc     <= '0;
            step    <= '0;
            div_rem <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        len_m1  <= cmd_len_m1;
                        from_q  <= cmd_from;
                        to_q    <= cmd_to;
                        idx     <= '0;
                        acc     <= '0;
                        div_rem <= '0;
                        div_cnt <= CNT_W'(ACC_W - 1);
                        step    <= (cmd_len_m1 == '0) ? '0 : DIVIDEND;
                    end
                end
                DIV: begin
                    div_rem <= rem_next;
                    step    <= {step[ACC_W-2:0], div_ge};
                    div_cnt <= div_cnt - 1'b1;
                end
                RUN: begin
                    if (core_fire && !core_last) begin
                        idx <= idx + 1'b1;
                        acc <= acc + step;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAPH_SPAN_SKID_EN
    localparam int BEAT_W = 8 + 32 + 32 + LEN_W + 1;

    logic [BEAT_W-1:0] core_beat, out_beat, skid_beat;
    logic              out_valid, skid_valid;

    assign core_beat  = {core_coeff, from_q, to_q, idx, core_last};
    // Only the registered skid occupancy gates the core, so px_ready never reaches idx/acc.
    assign core_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_beat   <= '0;
            skid_valid <= 1'b0;
            skid_beat  <= '0;
        end else if (!out_valid || px_ready) begin
            out_valid  <= skid_valid | core_fire;
            if (skid_valid)     out_beat <= skid_beat;
            else if (core_fire) out_beat <= core_beat;
            skid_valid <= 1'b0;
        end else if (core_fire) begin
            skid_valid <= 1'b1;
            skid_beat  <= core_beat;
        end
    end

    assign px_valid = out_valid;
    assign {px_coeff, px_from, px_to, px_idx, px_last} = out_beat;
`else
    assign core_ready = px_ready;
    assign px_valid   = core_valid;
    assign px_coeff   = core_coeff;
    assign px_from    = from_q;
    assign px_to      = to_q;
    assign px_idx     = idx;
    assign px_last    = core_last & core_valid;
`endif

endmodule
